// File: rtl/bus_pkg.sv
// Shared bus definitions: address/data widths and completion status codes.
package bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/bus_if.sv
// Single-outstanding request/ready transaction bus.
interface bus_if;

  logic                       valid;
  logic                       wr_en;
  logic [bus_pkg::ADDR_W-1:0] addr;
  logic [bus_pkg::DATA_W-1:0] wdata;
  logic                       ready;
  logic [bus_pkg::DATA_W-1:0] rdata;
  bus_pkg::resp_t             resp;

  modport slave (
    input  valid,
    input  wr_en,
    input  addr,
    input  wdata,
    output ready,
    output rdata,
    output resp
  );

  modport master (
    output valid,
    output wr_en,
    output addr,
    output wdata,
    input  ready,
    input  rdata,
    input  resp
  );

endinterface

// File: rtl/slave_regfile.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read port,
// asynchronous active-low clear of every word.
module slave_regfile #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [31:0] waddr_ext;
  logic [31:0] raddr_ext;

  assign waddr_ext = 32'(waddr);
  assign raddr_ext = 32'(raddr);

  // Word storage with asynchronous clear; writes outside DEPTH are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr_ext < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read; indices past DEPTH (non power-of-two depths) read as zero.
  always_comb begin
    rdata = '0;
    if (raddr_ext < DEPTH) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Memory-mapped storage slave: captures a request in IDLE, optionally waits
// WAIT_CYCLES cycles, then issues a one-cycle registered ready pulse with status.
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h40,
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  bus_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_t;

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  resp_t               resp_q, resp_d;

  logic                complete;
  logic                req_wr;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [ADDR_W-1:0]   index;
  logic                in_range;
  logic [DATA_W-1:0]   rf_rdata;

  // With zero wait states the request completes on the capturing edge, so the
  // decode must look at the live bus while idle and at the captured copy otherwise.
  always_comb begin
    req_wr    = wr_q;
    req_addr  = addr_q;
    req_wdata = wdata_q;
    if (state_q == StIdle) begin
      req_wr    = bus.wr_en;
      req_addr  = bus.addr;
      req_wdata = bus.wdata;
    end
  end

  // Address decode: unsigned offset from BASE_ADDR must land inside DEPTH.
  always_comb begin
    index    = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && (32'(index) < DEPTH);
  end

  slave_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IdxW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (complete && req_wr && in_range),
    .waddr (index[IdxW-1:0]),
    .wdata (req_wdata),
    .raddr (index[IdxW-1:0]),
    .rdata (rf_rdata)
  );

  // Next-state, capture and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.valid) begin
          wr_d    = bus.wr_en;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d  = StResp;
            complete = 1'b1;
          end
        end
      end
      StWait: begin
        // A dropped valid aborts even on the final wait cycle.
        if (!bus.valid) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d  = StResp;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response registers are loaded only on the edge entering RESP, zero otherwise.
  always_comb begin
    ready_d = complete;
    rdata_d = '0;
    resp_d  = RESP_OKAY;
    if (complete) begin
      if (!in_range) begin
        resp_d = RESP_SLVERR;
      end else if (!req_wr) begin
        rdata_d = rf_rdata;
      end
    end
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.resp  = resp_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Self-checking bench: two slaves (2 and 0 wait states) against a storage model.
module tb_bus_mem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  bus_if b2 ();
  bus_if b0 ();

  bus_mem_slave #(
    .BASE_ADDR   (8'h40),
    .DEPTH       (16),
    .WAIT_CYCLES (2)
  ) dut_w2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  bus_mem_slave #(
    .BASE_ADDR   (8'h40),
    .DEPTH       (16),
    .WAIT_CYCLES (0)
  ) dut_w0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  always #5 clk = ~clk;

  // Reference storage, one per slave (sel 0 = two waits, sel 1 = zero waits).
  logic [31:0] m2 [16];
  logic [31:0] m0 [16];

  typedef struct {
    bit          sel;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? b0.ready : b2.ready;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? b0.rdata : b2.rdata;
  endfunction

  function automatic logic [1:0] get_resp(input bit sel);
    return sel ? b0.resp : b2.resp;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic w, input logic [7:0] a,
                       input logic [31:0] d);
    if (sel) begin
      b0.valid = v; b0.wr_en = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.valid = v; b2.wr_en = w; b2.addr = a; b2.wdata = d;
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) b0.valid = v;
    else     b2.valid = v;
  endtask

  // Spec-level model: in range iff 0 <= addr-0x40 < 16; writes return zero data.
  task automatic model_txn(input bit sel, input bit wr, input logic [7:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic [1:0] rs);
    int idx;
    idx = int'(a) - 64;
    rd  = 32'h0;
    rs  = 2'b00;
    if (idx >= 0 && idx < 16) begin
      if (wr) begin
        if (sel) m0[idx] = d;
        else     m2[idx] = d;
      end else begin
        rd = sel ? m0[idx] : m2[idx];
      end
    end else begin
      rs = 2'b10;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m2[i] = 32'h0;
      m0[i] = 32'h0;
    end
  endtask

  // Waits (bounded) for a ready pulse; lat = cycles counted, -1 on timeout.
  task automatic wait_ready(input bit sel, input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget && lat < 0; c++) begin
      @(posedge clk); #1;
      if (get_ready(sel)) lat = c;
    end
  endtask

  // Complete one transaction holding valid until ready; checks the pulse is one cycle.
  task automatic txn(input bit sel, input bit wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic [1:0] rs, output int lat);
    drive(sel, 1'b1, wr, a, d);
    wait_ready(sel, 20, lat);
    rd = get_rdata(sel);
    rs = get_resp(sel);
    set_valid(sel, 1'b0);
    @(posedge clk); #1;
    chk("pulse_width_ready", 32'(get_ready(sel)), 32'h0);
  endtask

  task automatic count_pulses(input bit sel, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (get_ready(sel)) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, erd;
    logic [1:0]  rs, ers;
    int          lat, lat2, n;
    bit          sel, wr;
    logic [7:0]  a;
    logic [31:0] d;

    tbl[0]  = '{0, 1, 8'h41, 32'hDEADBEEF, 32'h0,        2'b00};
    tbl[1]  = '{0, 0, 8'h41, 32'h0,        32'hDEADBEEF, 2'b00};
    tbl[2]  = '{0, 0, 8'h60, 32'h0,        32'h0,        2'b10};
    tbl[3]  = '{0, 0, 8'h40, 32'h0,        32'h0,        2'b00};
    tbl[4]  = '{0, 1, 8'h3F, 32'h11111111, 32'h0,        2'b10};
    tbl[5]  = '{0, 1, 8'h4F, 32'hA5A5A5A5, 32'h0,        2'b00};
    tbl[6]  = '{0, 0, 8'h4F, 32'hFFFFFFFF, 32'hA5A5A5A5, 2'b00};
    tbl[7]  = '{0, 1, 8'h50, 32'h22222222, 32'h0,        2'b10};
    tbl[8]  = '{0, 0, 8'h3F, 32'h0,        32'h0,        2'b10};
    tbl[9]  = '{1, 1, 8'h4F, 32'hCAFEF00D, 32'h0,        2'b00};
    tbl[10] = '{1, 0, 8'h4F, 32'h0,        32'hCAFEF00D, 2'b00};
    tbl[11] = '{1, 0, 8'h60, 32'h0,        32'h0,        2'b10};
    tbl[12] = '{0, 0, 8'h4F, 32'h0,        32'hA5A5A5A5, 2'b00};
    tbl[13] = '{0, 0, 8'hFF, 32'h0,        32'h0,        2'b10};

    clear_model();
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 32'h0);

    // Reset state
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_w2", 32'(b2.ready), 32'h0);
    chk("reset_rdata_w2", b2.rdata, 32'h0);
    chk("reset_resp_w2", 32'(b2.resp), 32'h0);
    chk("reset_ready_w0", 32'(b0.ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) begin
      model_txn(tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].wdata, erd, ers);
      txn(tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, rs, lat);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), tbl[i].sel ? 32'd1 : 32'd3);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_resp", i), 32'(rs), 32'(tbl[i].exp_resp));
    end

    // Abort: valid dropped after one cycle in WAIT
    drive(0, 1'b1, 1'b1, 8'h42, 32'h1234);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_valid(0, 1'b0);
    count_pulses(0, 6, n);
    chk("abort_no_ready", 32'(n), 32'h0);
    model_txn(0, 0, 8'h42, 32'h0, erd, ers);
    txn(0, 0, 8'h42, 32'h0, rd, rs, lat);
    chk("abort_read_back", rd, erd);

    // Bus changes after capture are ignored
    drive(0, 1'b1, 1'b1, 8'h46, 32'h7777);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h47, 32'h9999);
    wait_ready(0, 20, lat);
    chk("midchange_latency", 32'(lat), 32'd2);
    chk("midchange_resp", 32'(b2.resp), 32'h0);
    chk("midchange_rdata", b2.rdata, 32'h0);
    set_valid(0, 1'b0);
    model_txn(0, 1, 8'h46, 32'h7777, erd, ers);
    @(posedge clk); #1;
    model_txn(0, 0, 8'h46, 32'h0, erd, ers);
    txn(0, 0, 8'h46, 32'h0, rd, rs, lat);
    chk("midchange_rd46", rd, erd);
    model_txn(0, 0, 8'h47, 32'h0, erd, ers);
    txn(0, 0, 8'h47, 32'h0, rd, rs, lat);
    chk("midchange_rd47", rd, erd);

    // Back-to-back writes with valid held across ready
    drive(0, 1'b1, 1'b1, 8'h44, 32'h1111);
    wait_ready(0, 20, lat);
    chk("b2b_first_latency", 32'(lat), 32'd3);
    drive(0, 1'b1, 1'b1, 8'h45, 32'h2222);
    wait_ready(0, 20, lat2);
    chk("b2b_gap", 32'(lat2), 32'd4);
    set_valid(0, 1'b0);
    model_txn(0, 1, 8'h44, 32'h1111, erd, ers);
    model_txn(0, 1, 8'h45, 32'h2222, erd, ers);
    count_pulses(0, 4, n);
    chk("b2b_no_extra", 32'(n), 32'h0);
    model_txn(0, 0, 8'h44, 32'h0, erd, ers);
    txn(0, 0, 8'h44, 32'h0, rd, rs, lat);
    chk("b2b_rd44", rd, erd);
    model_txn(0, 0, 8'h45, 32'h0, erd, ers);
    txn(0, 0, 8'h45, 32'h0, rd, rs, lat);
    chk("b2b_rd45", rd, erd);

    // Randomized traffic on both slaves
    for (int k = 0; k < 40; k++) begin
      sel = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      a   = 8'h38 + 8'($urandom_range(0, 31));
      d   = $urandom;
      model_txn(sel, wr, a, d, erd, ers);
      txn(sel, wr, a, d, rd, rs, lat);
      chk($sformatf("rand%0d_latency", k), 32'(lat), sel ? 32'd1 : 32'd3);
      chk($sformatf("rand%0d_rdata", k), rd, erd);
      chk($sformatf("rand%0d_resp", k), 32'(rs), 32'(ers));
    end

    // Asynchronous reset while ready is high
    model_txn(0, 1, 8'h41, 32'h600DF00D, erd, ers);
    txn(0, 1, 8'h41, 32'h600DF00D, rd, rs, lat);
    drive(0, 1'b1, 1'b0, 8'h41, 32'h0);
    wait_ready(0, 20, lat);
    chk("pre_reset_rdata", b2.rdata, 32'h600DF00D);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_ready", 32'(b2.ready), 32'h0);
    chk("async_reset_rdata", b2.rdata, 32'h0);
    set_valid(0, 1'b0);
    clear_model();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT of a write
    drive(0, 1'b1, 1'b1, 8'h43, 32'h5555);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("wait_reset_ready", 32'(b2.ready), 32'h0);
    chk("wait_reset_resp", 32'(b2.resp), 32'h0);
    set_valid(0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    count_pulses(0, 5, n);
    chk("wait_reset_no_ready", 32'(n), 32'h0);
    model_txn(0, 0, 8'h43, 32'h0, erd, ers);
    txn(0, 0, 8'h43, 32'h0, rd, rs, lat);
    chk("wait_reset_rd43", rd, erd);
    model_txn(0, 0, 8'h41, 32'h0, erd, ers);
    txn(0, 0, 8'h41, 32'h0, rd, rs, lat);
    chk("storage_cleared_rd41", rd, erd);
    model_txn(1, 0, 8'h4F, 32'h0, erd, ers);
    txn(1, 0, 8'h4F, 32'h0, rd, rs, lat);
    chk("storage_cleared_w0_rd4f", rd, erd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

Interface
REQ-001 Parameter BASE_ADDR, default 8'h40: first bus address decoded by this slave.
REQ-002 Parameter DEPTH, default 16: number of DATA_W-bit storage words.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted before ready; legal range 0..15.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk and rst_n.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 bus  bus_if (slave side)  -  transaction port; member directions follow.
REQ-008 bus.valid  input  1  request present; held by upstream until ready.
REQ-009 bus.wr_en  input  1  1 = write, 0 = read.
REQ-010 bus.addr  input  ADDR_W (8)  absolute byte-free word address.
REQ-011 bus.wdata  input  DATA_W  write data.
REQ-012 bus.ready  output  1  one-cycle completion pulse.
REQ-013 bus.rdata  output  DATA_W  read data, valid only while ready=1.
REQ-014 bus.resp  output  resp_t  completion status, valid only while ready=1.

Function
REQ-015 FSM states IDLE, WAIT, RESP; all outputs driven from registers.
REQ-016 IDLE: valid=1 captures wr_en, addr, wdata; next state WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 WAIT: down-counter loaded with WAIT_CYCLES-1 on entry; decrements each cycle; at 0 -> RESP.
REQ-018 RESP: ready=1 for exactly one cycle with rdata/resp; next state IDLE unconditionally.
REQ-019 Latency: valid sampled in IDLE at edge N -> ready high during cycle N+WAIT_CYCLES+1.
REQ-020 Local index = addr - BASE_ADDR (ADDR_W unsigned); in range iff addr >= BASE_ADDR and index < DEPTH.
REQ-021 In-range write: word[index] <= captured wdata on the edge entering RESP; resp=RESP_OKAY, rdata=0.
REQ-022 In-range read: rdata = word[index] as read on the edge entering RESP; resp=RESP_OKAY.
REQ-023 Out-of-range access: no storage change, rdata=0, resp=RESP_SLVERR.
REQ-024 valid deasserted while in WAIT: abort, return to IDLE next edge, no write, no ready pulse.
REQ-025 Captured request fields are not re-sampled after IDLE; bus changes mid-transaction are ignored.
REQ-026 valid still high in the IDLE cycle following RESP: treated as a new transaction (back-to-back allowed).
REQ-027 Outside RESP: ready=0, rdata=0, resp=RESP_OKAY.

Reset
REQ-028 rst_n low: state=IDLE, counter=0, ready=0, rdata=0, resp=RESP_OKAY, captured fields 0, immediately (asynchronous).
REQ-029 Reset mid-transaction discards it; no write performed, no ready pulse after release.
REQ-030 Storage words reset to 0.

Structure
REQ-031 bus_pkg holds ADDR_W, DATA_W and resp_t (RESP_OKAY=2'b00, RESP_SLVERR=2'b10); this block adds RESP_SLVERR if absent.
REQ-032 One sub-module slave_regfile (DEPTH x DATA_W, one synchronous write port, one combinational read port, async active-low clear).
REQ-033 FSM, wait counter and decode stay in bus_mem_slave.

Verification
REQ-034 Write 0x41 data 0xDEADBEEF, WAIT_CYCLES=2 -> ready in cycle 3 after valid, resp=OKAY; read 0x41 -> rdata=0xDEADBEEF.
REQ-035 Read 0x60 (index 32 >= DEPTH 16) -> resp=RESP_SLVERR, rdata=0; read 0x40 afterwards unchanged.
REQ-036 WAIT_CYCLES=0: read 0x4F -> ready in cycle 1 after valid, rdata = last written value.
REQ-037 Write 0x42 data 0x1234, drop valid after 1 cycle in WAIT -> no ready; read 0x42 returns 0.
REQ-038 rst_n low during WAIT of write 0x43 data 0x5555 -> outputs 0 immediately; read 0x43 after release returns 0.
REQ-039 Two back-to-back writes, valid held high across ready -> two ready pulses, both words updated.
